// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetch stage with one-entry last-fetch buffer
module instr_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int COUNT_BITS            = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_hit,
  output logic [COUNT_BITS-1:0]            miss_count
);

  localparam logic [2:0]            CORE_FETCH  = 3'b001;
  localparam logic [2:0]            CORE_DECODE = 3'b010;
  localparam logic [COUNT_BITS-1:0] COUNT_ONE   = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_e;

  state_e                             state_q, state_d;
  logic                               rd_valid_q, rd_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q, instr_d;
  logic                               hit_q, hit_d;
  logic [COUNT_BITS-1:0]              miss_q, miss_d;
  logic                               buf_valid_q, buf_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   buf_tag_q, buf_tag_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   buf_data_q, buf_data_d;
  logic                               buf_hit;

  // A same-cycle invalidate forces the miss path even when the tag matches.
  assign buf_hit = buf_valid_q && (buf_tag_q == current_pc) && !invalidate;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= '0;
      instr_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      instr_q     <= instr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_valid_d  = rd_valid_q;
    rd_addr_d   = rd_addr_q;
    instr_d     = instr_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;

    case (state_q)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (buf_hit) begin
            state_d = FETCHED;
            instr_d = buf_data_q;
            hit_d   = 1'b1;
          end else begin
            state_d    = FETCHING;
            rd_valid_d = 1'b1;
            rd_addr_d  = current_pc;
            if (miss_q != '1) begin
              miss_d = miss_q + COUNT_ONE;
            end
          end
        end
      end
      FETCHING: begin
        if (mem_read_ready) begin
          state_d     = FETCHED;
          rd_valid_d  = 1'b0;
          instr_d     = mem_read_data;
          hit_d       = 1'b0;
          buf_valid_d = 1'b1;
          buf_tag_d   = rd_addr_q;
          buf_data_d  = mem_read_data;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = IDLE;
          hit_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied last so it also discards a fill landing in the same cycle.
    if (invalidate) begin
      buf_valid_d = 1'b0;
    end
  end

  assign fetcher_state    = state_q;
  assign mem_read_valid   = rd_valid_q;
  assign mem_read_address = rd_addr_q;
  assign instruction      = instr_q;
  assign fetch_hit        = hit_q;
  assign miss_count       = miss_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - self-checking bench for instr_fetcher
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic        fetch_hit;
  logic [15:0] miss_count;

  logic        s_valid;
  logic [7:0]  s_addr;
  logic [2:0]  s_state;
  logic [15:0] s_instr;
  logic        s_hit;
  logic [1:0]  s_miss;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_fetcher dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .invalidate(invalidate), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction), .fetch_hit(fetch_hit), .miss_count(miss_count)
  );

  instr_fetcher #(.COUNT_BITS(2)) u_sat (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .invalidate(invalidate), .mem_read_valid(s_valid),
    .mem_read_address(s_addr), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(s_state),
    .instruction(s_instr), .fetch_hit(s_hit), .miss_count(s_miss)
  );

  typedef struct {
    logic [7:0]  pc;
    logic        inv;
    int          waits;
    logic [15:0] data;
    logic        inv_rdy;
    logic        stray;
    logic        exp_hit;
    logic [15:0] exp_instr;
    logic [15:0] exp_miss;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_fetch(input logic [7:0] pc, input logic inv, input int waits,
                          input logic [15:0] data, input logic inv_rdy, input logic stray,
                          input logic exp_hit, input logic [15:0] exp_instr,
                          input logic [15:0] exp_miss);
    core_state = 3'b001;
    current_pc = pc;
    invalidate = inv;
    @(negedge clk);
    core_state = 3'b000;
    invalidate = 1'b0;
    if (exp_hit) begin
      chk("hit_state", 32'(fetcher_state), 32'd2);
      chk("hit_flag", 32'(fetch_hit), 32'd1);
      chk("hit_no_req", 32'(mem_read_valid), 32'd0);
    end else begin
      chk("req_state", 32'(fetcher_state), 32'd1);
      chk("req_valid", 32'(mem_read_valid), 32'd1);
      chk("req_addr", 32'(mem_read_address), 32'(pc));
      for (int i = 0; i < waits; i++) begin
        current_pc = pc ^ 8'h5A;
        @(negedge clk);
        chk("wait_valid", 32'(mem_read_valid), 32'd1);
        chk("wait_addr", 32'(mem_read_address), 32'(pc));
      end
      mem_read_ready = 1'b1;
      mem_read_data  = data;
      invalidate     = inv_rdy;
      @(negedge clk);
      mem_read_ready = 1'b0;
      invalidate     = 1'b0;
      mem_read_data  = 16'($urandom);
      chk("fill_state", 32'(fetcher_state), 32'd2);
      chk("fill_valid", 32'(mem_read_valid), 32'd0);
      chk("fill_hit", 32'(fetch_hit), 32'd0);
    end
    chk("instr", 32'(instruction), 32'(exp_instr));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
    if (stray) begin
      mem_read_ready = 1'b1;
      mem_read_data  = ~exp_instr;
      @(negedge clk);
      mem_read_ready = 1'b0;
      chk("stray_state", 32'(fetcher_state), 32'd2);
      chk("stray_instr", 32'(instruction), 32'(exp_instr));
      chk("stray_valid", 32'(mem_read_valid), 32'd0);
    end
    core_state = 3'b010;
    @(negedge clk);
    core_state = 3'b000;
    chk("decode_state", 32'(fetcher_state), 32'd0);
    chk("decode_hit", 32'(fetch_hit), 32'd0);
    chk("decode_instr", 32'(instruction), 32'(exp_instr));
  endtask

  logic        m_valid;
  logic [7:0]  m_tag;
  logic [15:0] m_data;
  logic [15:0] m_miss;

  initial begin
    vecs[0]  = '{8'h05, 1'b0, 3, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 16'd1};
    vecs[1]  = '{8'h05, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 16'd1};
    vecs[2]  = '{8'h05, 1'b1, 0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'd2};
    vecs[3]  = '{8'h05, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'd2};
    vecs[4]  = '{8'h10, 1'b0, 2, 16'hABCD, 1'b0, 1'b1, 1'b0, 16'hABCD, 16'd3};
    vecs[5]  = '{8'h10, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'd3};
    vecs[6]  = '{8'hFF, 1'b0, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'd4};
    vecs[7]  = '{8'h00, 1'b0, 0, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0001, 16'd5};
    vecs[8]  = '{8'h07, 1'b0, 1, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h7777, 16'd6};
    vecs[9]  = '{8'h07, 1'b0, 0, 16'h7778, 1'b0, 1'b0, 1'b0, 16'h7778, 16'd7};
    vecs[10] = '{8'h07, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h7778, 16'd7};

    core_state     = 3'b000;
    current_pc     = 8'h00;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    reset          = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(fetcher_state), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_addr", 32'(mem_read_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_hit", 32'(fetch_hit), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_fetch(vecs[i].pc, vecs[i].inv, vecs[i].waits, vecs[i].data, vecs[i].inv_rdy,
               vecs[i].stray, vecs[i].exp_hit, vecs[i].exp_instr, vecs[i].exp_miss);
    end

    // Reset while a request is outstanding drops it and empties the buffer.
    core_state = 3'b001;
    current_pc = 8'h30;
    @(negedge clk);
    core_state = 3'b000;
    chk("pre_rst_state", 32'(fetcher_state), 32'd1);
    do_reset();
    chk("mid_rst_state", 32'(fetcher_state), 32'd0);
    chk("mid_rst_valid", 32'(mem_read_valid), 32'd0);
    chk("mid_rst_addr", 32'(mem_read_address), 32'd0);
    chk("mid_rst_instr", 32'(instruction), 32'd0);
    chk("mid_rst_hit", 32'(fetch_hit), 32'd0);
    chk("mid_rst_miss", 32'(miss_count), 32'd0);
    do_fetch(8'h07, 1'b0, 0, 16'h0707, 1'b0, 1'b0, 1'b0, 16'h0707, 16'd1);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_fetch(8'h40 + 8'(i), 1'b0, 0, 16'h4000 + 16'(i), 1'b0, 1'b0, 1'b0,
               16'h4000 + 16'(i), 16'(i + 1));
      chk("sat_miss", 32'(s_miss), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    do_reset();
    m_valid = 1'b0;
    m_tag   = 8'h00;
    m_data  = 16'h0000;
    m_miss  = 16'd0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  pc;
      logic        inv, inv_rdy, stray, hit;
      int          waits;
      logic [15:0] data, exp_instr;
      pc      = 8'($urandom_range(0, 3));
      inv     = ($urandom_range(0, 4) == 0);
      waits   = $urandom_range(0, 3);
      data    = 16'($urandom);
      inv_rdy = ($urandom_range(0, 5) == 0);
      stray   = ($urandom_range(0, 1) == 1);
      hit     = m_valid && (m_tag == pc) && !inv;
      if (hit) begin
        exp_instr = m_data;
      end else begin
        if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
        m_valid   = !inv_rdy;
        m_tag     = pc;
        m_data    = data;
        exp_instr = data;
      end
      do_fetch(pc, inv, waits, data, inv_rdy, stray, hit, exp_instr, m_miss);
      if ($urandom_range(0, 7) == 0) begin
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        m_valid    = 1'b0;
        chk("idle_inv_state", 32'(fetcher_state), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
- Per-core instruction fetch stage, upstream of the per-thread PC units and the decoder.
- When the core scheduler enters FETCH, it fetches the instruction at current_pc from the program memory controller over a valid/ready read channel.
- Holds the instruction stable for decode and reports completion through fetcher_state.
- Keeps a one-entry last-fetch buffer (tag + data). Tight loops that re-fetch the same PC skip the memory round trip.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, width of program memory address / PC.
- PROGRAM_MEM_DATA_BITS, 16, width of one instruction word.
- COUNT_BITS, 16, width of the saturating miss counter.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- core_state, input, 3, scheduler state; FETCH=3'b001, DECODE=3'b010, others ignored.
- current_pc, input, PROGRAM_MEM_ADDR_BITS, PC to fetch; sampled on FETCH entry.
- invalidate, input, 1, clears the last-fetch buffer (kernel launch / program reload).
- mem_read_valid, output, 1, read request to program memory controller.
- mem_read_address, output, PROGRAM_MEM_ADDR_BITS, request address.
- mem_read_ready, input, 1, controller response strobe; data valid this cycle.
- mem_read_data, input, PROGRAM_MEM_DATA_BITS, returned instruction.
- fetcher_state, output, 3, IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
- instruction, output, PROGRAM_MEM_DATA_BITS, fetched instruction; stable while FETCHED.
- fetch_hit, output, 1, high while FETCHED if the instruction came from the buffer.
- miss_count, output, COUNT_BITS, number of memory requests issued; saturates at all-ones.

Behaviour:
- Reset values:
  - fetcher_state=IDLE.
  - mem_read_valid=0, mem_read_address=0.
  - instruction=0, fetch_hit=0, miss_count=0.
  - Buffer valid=0, tag=0, data=0.
- Reset has priority over every other input, including mid-request. The memory controller must tolerate a dropped request.
- All outputs are registered.
- IDLE, core_state==FETCH, buffer valid, tag==current_pc, invalidate=0 (hit):
  - Next cycle: fetcher_state=FETCHED, instruction=buffer data, fetch_hit=1.
  - No memory request. Latency 1 cycle.
- IDLE, core_state==FETCH, any other case (miss):
  - Next cycle: fetcher_state=FETCHING, mem_read_valid=1, mem_read_address=current_pc.
  - miss_count increments by 1 unless already all-ones.
- IDLE, core_state not FETCH: hold all outputs.
- FETCHING:
  - mem_read_valid and mem_read_address are held constant until mem_read_ready=1.
  - current_pc changes are ignored.
- FETCHING, mem_read_ready=1:
  - Next cycle: mem_read_valid=0, instruction=mem_read_data, fetch_hit=0, fetcher_state=FETCHED.
  - Buffer loads tag=mem_read_address, data=mem_read_data, valid=1.
  - If invalidate is high in this same cycle, valid=0 and the fill is not retained.
  - Minimum miss latency: ready in the first FETCHING cycle gives FETCHED 2 cycles after FETCH entry.
- mem_read_ready is ignored in IDLE and FETCHED. Stray strobes cause no state change.
- FETCHED:
  - Hold instruction and fetch_hit.
  - On core_state==DECODE, next cycle: fetcher_state=IDLE, fetch_hit=0. instruction keeps its value.
- invalidate in any state clears buffer valid next cycle. It does not abort an in-flight request and does not alter instruction.
- invalidate and a hit condition in the same IDLE cycle: invalidate wins, the fetch is treated as a miss.
- Tag compare is full-width equality, so PC wrap from all-ones to 0 needs no special case.
- Unused core_state encodings are treated as "not FETCH / not DECODE".

Test Plan:
- Reset, then FETCH with current_pc=0x05, ready after 3 wait cycles with data=0x1234:
  - mem_read_valid=1 and addr=0x05 for 4 cycles.
  - Then FETCHED, instruction=0x1234, fetch_hit=0, miss_count=1.
- DECODE, IDLE, then FETCH again with pc=0x05:
  - FETCHED next cycle, instruction=0x1234, fetch_hit=1, mem_read_valid never rises, miss_count stays 1.
- FETCH pc=0x05 with invalidate=1 in the same cycle:
  - Miss path taken, request to 0x05, miss_count=2.
- During FETCHING at pc=0x10: change current_pc to 0x20 and pulse mem_read_ready while FETCHED:
  - Address stays 0x10.
  - The stray ready causes no change.
  - Buffer tag=0x10 (a later FETCH at 0x10 hits).
- Assert reset while FETCHING:
  - Next cycle all outputs are zero and state is IDLE.
  - A following FETCH at a previously buffered PC misses.
- Preload miss_count near all-ones (COUNT_BITS=2, 4 misses at distinct PCs):
  - miss_count sequence 1,2,3,3.
